// File: rtl/bextdep_arbiter.sv
// bextdep_arbiter: shares one in-order bext/bdep unit between two requesters.
// Round-robin issue, tag FIFO of requester IDs routes results back in order.
// Optional BEXTDEP_ARB_STATS_EN adds saturating issue/conflict counters.
module bextdep_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_bdep,
   input  logic [31:0] req0_value,
   input  logic [31:0] req0_mask,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_bdep,
   input  logic [31:0] req1_value,
   input  logic [31:0] req1_mask,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_result,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_result,
   output logic        u_din_valid,
   input  logic        u_din_ready,
   output logic        u_din_bdep,
   output logic [31:0] u_din_value,
   output logic [31:0] u_din_mask,
   input  logic        u_dout_valid,
   output logic        u_dout_ready,
   input  logic [31:0] u_dout_result
`ifdef BEXTDEP_ARB_STATS_EN
   ,
   output logic [31:0] stat_issue0,
   output logic [31:0] stat_issue1,
   output logic [31:0] stat_conflict
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_MAX = DEPTH[AW:0];

   logic [DEPTH-1:0] tag_q;
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic [AW:0]      count;
   logic             last;

   logic both, gnt_vld, gnt_id, full, issue_ok, has_out, head, push, pop;

   // Grant, issue and response routing; all combinational so issue adds no latency.
   always_comb begin
      both     = req0_valid & req1_valid;
      gnt_vld  = req0_valid | req1_valid;
      gnt_id   = both ? ~last : req1_valid;
      full     = (count == CNT_MAX);
      // Gate with reset so every handshake output is low while reset is held.
      issue_ok = gnt_vld & ~full & ~reset;

      u_din_valid = issue_ok;
      req0_ready  = issue_ok & ~gnt_id & u_din_ready;
      req1_ready  = issue_ok &  gnt_id & u_din_ready;
      u_din_bdep  = 1'b0;
      u_din_value = '0;
      u_din_mask  = '0;
      if (gnt_vld) begin
         u_din_bdep  = gnt_id ? req1_bdep  : req0_bdep;
         u_din_value = gnt_id ? req1_value : req0_value;
         u_din_mask  = gnt_id ? req1_mask  : req0_mask;
      end

      // A result with no tag outstanding is a protocol error and is never accepted.
      has_out      = (count != '0) & ~reset;
      head         = tag_q[rd_ptr];
      rsp0_valid   = u_dout_valid & has_out & ~head;
      rsp1_valid   = u_dout_valid & has_out &  head;
      rsp0_result  = u_dout_result;
      rsp1_result  = u_dout_result;
      u_dout_ready = has_out & (head ? rsp1_ready : rsp0_ready);

      // Full blocks push even when a pop frees a slot: keeps rsp ready off the issue path.
      push = issue_ok & u_din_ready;
      pop  = u_dout_valid & u_dout_ready;
   end

   // Tag FIFO, occupancy and round-robin pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_q  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         last   <= 1'b1;
      end else begin
         if (push) begin
            tag_q[wr_ptr] <= gnt_id;
            wr_ptr        <= wr_ptr + 1'b1;
            last          <= gnt_id;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef BEXTDEP_ARB_STATS_EN
   logic conflict;
   assign conflict = both & (~u_din_ready | full);

   // Saturating per-requester issue counters and contention-stall counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_issue0   <= '0;
         stat_issue1   <= '0;
         stat_conflict <= '0;
      end else begin
         if (push && !gnt_id && stat_issue0 != '1)
            stat_issue0 <= stat_issue0 + 1'b1;
         if (push && gnt_id && stat_issue1 != '1)
            stat_issue1 <= stat_issue1 + 1'b1;
         if (conflict && stat_conflict != '1)
            stat_conflict <= stat_conflict + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bextdep_arbiter.sv
// Bench for bextdep_arbiter: behavioural in-order unit, per-requester result
// scoreboards filled at issue, grant log for round-robin order checks.
module tb_bextdep_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 0, req0_bdep = 0, req1_valid = 0, req1_bdep = 0;
   logic [31:0] req0_value = 0, req0_mask = 0, req1_value = 0, req1_mask = 0;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready = 1, rsp1_ready = 1;
   logic [31:0] rsp0_result, rsp1_result;
   logic        u_din_valid, u_din_ready, u_din_bdep;
   logic [31:0] u_din_value, u_din_mask;
   logic        u_dout_valid = 0, u_dout_ready;
   logic [31:0] u_dout_result = 0;
   logic        unit_rdy = 1;
`ifdef BEXTDEP_ARB_STATS_EN
   logic [31:0] stat_issue0, stat_issue1, stat_conflict;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp0[$];
   logic [31:0] exp1[$];
   logic [31:0] uq[$];
   int          gnt_log[$];
   logic        rsp1_seen = 0;

   always #5 clock = ~clock;
   assign u_din_ready = unit_rdy;

   bextdep_arbiter #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bdep(req0_bdep),
      .req0_value(req0_value), .req0_mask(req0_mask),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bdep(req1_bdep),
      .req1_value(req1_value), .req1_mask(req1_mask),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .u_din_valid(u_din_valid), .u_din_ready(u_din_ready), .u_din_bdep(u_din_bdep),
      .u_din_value(u_din_value), .u_din_mask(u_din_mask),
      .u_dout_valid(u_dout_valid), .u_dout_ready(u_dout_ready),
      .u_dout_result(u_dout_result)
`ifdef BEXTDEP_ARB_STATS_EN
      ,
      .stat_issue0(stat_issue0), .stat_issue1(stat_issue1), .stat_conflict(stat_conflict)
`endif
   );

   function automatic logic [31:0] ref_op(input logic bdep, input logic [31:0] v,
                                          input logic [31:0] m);
      logic [31:0] r;
      int k;
      r = '0;
      k = 0;
      for (int i = 0; i < 32; i++)
         if (m[i]) begin
            if (bdep) r[i] = v[k];
            else      r[k] = v[i];
            k++;
         end
      return r;
   endfunction

   // Behavioural in-order unit with one cycle of latency and unlimited depth.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         uq.delete();
         u_dout_valid  <= 1'b0;
         u_dout_result <= '0;
      end else begin
         if (u_dout_valid && u_dout_ready) void'(uq.pop_front());
         if (u_din_valid && u_din_ready) uq.push_back(ref_op(u_din_bdep, u_din_value, u_din_mask));
         u_dout_valid  <= (uq.size() > 0);
         u_dout_result <= (uq.size() > 0) ? uq[0] : 32'h0;
      end
   end

   // Discard expectations for operations flushed by reset.
   always @(posedge reset) begin
      exp0.delete();
      exp1.delete();
   end

   // Mid-cycle monitor: records handshakes that complete at the next rising edge.
   always @(negedge clock) begin
      if (!reset) begin
         if (rsp1_valid) rsp1_seen = 1'b1;
         if (req0_ready && req1_ready) begin
            n_err++;
            $display("FAIL both_ready: req0_ready=1 req1_ready=1, want at most one");
         end
         if (rsp0_valid && rsp1_valid) begin
            n_err++;
            $display("FAIL both_rsp_valid: rsp0_valid=1 rsp1_valid=1, want at most one");
         end
         if (req0_valid && req0_ready) begin
            exp0.push_back(ref_op(req0_bdep, req0_value, req0_mask));
            gnt_log.push_back(0);
            n_vec++;
            if ({u_din_bdep, u_din_value, u_din_mask} !== {req0_bdep, req0_value, req0_mask}) begin
               n_err++;
               $display("FAIL fwd0: u_din=%b/%h/%h want %b/%h/%h", u_din_bdep, u_din_value,
                        u_din_mask, req0_bdep, req0_value, req0_mask);
            end
         end
         if (req1_valid && req1_ready) begin
            exp1.push_back(ref_op(req1_bdep, req1_value, req1_mask));
            gnt_log.push_back(1);
            n_vec++;
            if ({u_din_bdep, u_din_value, u_din_mask} !== {req1_bdep, req1_value, req1_mask}) begin
               n_err++;
               $display("FAIL fwd1: u_din=%b/%h/%h want %b/%h/%h", u_din_bdep, u_din_value,
                        u_din_mask, req1_bdep, req1_value, req1_mask);
            end
         end
         if (rsp0_valid && rsp0_ready) begin
            n_vec++;
            if (exp0.size() == 0) begin
               n_err++;
               $display("FAIL rsp0_unexpected: result %h with nothing outstanding", rsp0_result);
            end else begin
               logic [31:0] e;
               e = exp0.pop_front();
               if (rsp0_result !== e) begin
                  n_err++;
                  $display("FAIL rsp0_result: got %h want %h", rsp0_result, e);
               end
            end
         end
         if (rsp1_valid && rsp1_ready) begin
            n_vec++;
            if (exp1.size() == 0) begin
               n_err++;
               $display("FAIL rsp1_unexpected: result %h with nothing outstanding", rsp1_result);
            end else begin
               logic [31:0] e;
               e = exp1.pop_front();
               if (rsp1_result !== e) begin
                  n_err++;
                  $display("FAIL rsp1_result: got %h want %h", rsp1_result, e);
               end
            end
         end
      end
   end

   task automatic new_op0();
      req0_bdep  = 1'($urandom_range(0, 1));
      req0_value = $urandom;
      req0_mask  = $urandom;
   endtask

   task automatic new_op1();
      req1_bdep  = 1'($urandom_range(0, 1));
      req1_value = $urandom;
      req1_mask  = $urandom;
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Issue n0/n1 random ops, advancing each requester only after its handshake.
   task automatic run_ops(input int n0, input int n1, input int budget);
      int i0, i1, c;
      logic h0, h1;
      i0 = 0; i1 = 0; c = 0;
      if (n0 > 0) begin new_op0(); req0_valid = 1; end
      if (n1 > 0) begin new_op1(); req1_valid = 1; end
      while ((i0 < n0 || i1 < n1) && c < budget) begin
         @(negedge clock);
         h0 = req0_valid && req0_ready;
         h1 = req1_valid && req1_ready;
         cyc();
         c++;
         if (h0) begin i0++; if (i0 < n0) new_op0(); else req0_valid = 0; end
         if (h1) begin i1++; if (i1 < n1) new_op1(); else req1_valid = 0; end
      end
      req0_valid = 0;
      req1_valid = 0;
      n_vec++;
      if (i0 != n0 || i1 != n1) begin
         n_err++;
         $display("FAIL run_ops: issued %0d/%0d want %0d/%0d", i0, i1, n0, n1);
      end
   endtask

   task automatic drain(input int budget);
      int c;
      c = 0;
      rsp0_ready = 1;
      rsp1_ready = 1;
      while ((exp0.size() != 0 || exp1.size() != 0) && c < budget) begin
         cyc();
         c++;
      end
      cyc();
      cyc();
      n_vec++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d/%0d results outstanding want 0/0", exp0.size(), exp1.size());
      end
   endtask

   task automatic test_reset();
      req0_valid = 1;
      req1_valid = 1;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, u_din_valid, u_dout_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b want 000000", {req0_ready, req1_ready, rsp0_valid,
                  rsp1_valid, u_din_valid, u_dout_ready});
      end
      req0_valid = 0;
      req1_valid = 0;
      cyc();
      cyc();
      reset = 0;
      @(negedge clock);
      n_vec++;
      if ({u_din_valid, u_din_value, u_dout_ready} !== 34'h0) begin
         n_err++;
         $display("FAIL idle_after_reset: din_valid=%b din_value=%h dout_ready=%b want 0/0/0",
                  u_din_valid, u_din_value, u_dout_ready);
      end
   endtask

   task automatic test_single_bext();
      int c;
      cyc();
      rsp1_seen  = 0;
      req0_bdep  = 0;
      req0_value = 32'h12345678;
      req0_mask  = 32'h0000FF00;
      req0_valid = 1;
      @(negedge clock);
      n_vec++;
      if ({u_din_valid, req0_ready, u_din_bdep, u_din_value, u_din_mask} !==
          {1'b1, 1'b1, 1'b0, 32'h12345678, 32'h0000FF00}) begin
         n_err++;
         $display("FAIL bext_forward: v=%b r=%b b=%b %h %h want 1 1 0 12345678 0000ff00",
                  u_din_valid, req0_ready, u_din_bdep, u_din_value, u_din_mask);
      end
      cyc();
      req0_valid = 0;
      c = 0;
      do begin @(negedge clock); c++; end while (!rsp0_valid && c < 10);
      n_vec++;
      if (rsp0_valid !== 1'b1 || rsp0_result !== 32'h00000056) begin
         n_err++;
         $display("FAIL bext_result: valid=%b result=%h want 1/00000056", rsp0_valid, rsp0_result);
      end
      drain(20);
      n_vec++;
      if (rsp1_seen !== 1'b0) begin
         n_err++;
         $display("FAIL bext_port1: rsp1_valid seen=%b want 0", rsp1_seen);
      end
   endtask

   task automatic test_single_bdep();
      int c;
      logic r0seen;
      cyc();
      req1_bdep  = 1;
      req1_value = 32'h000000AB;
      req1_mask  = 32'h00FF0000;
      req1_valid = 1;
      @(negedge clock);
      n_vec++;
      if ({req1_ready, req0_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL bdep_ready: req1_ready=%b req0_ready=%b want 1/0", req1_ready, req0_ready);
      end
      cyc();
      req1_valid = 0;
      c = 0;
      r0seen = 0;
      do begin @(negedge clock); c++; r0seen |= rsp0_valid; end while (!rsp1_valid && c < 10);
      n_vec++;
      if (rsp1_valid !== 1'b1 || rsp1_result !== 32'h00AB0000 || r0seen !== 1'b0) begin
         n_err++;
         $display("FAIL bdep_result: valid=%b result=%h rsp0_seen=%b want 1/00ab0000/0",
                  rsp1_valid, rsp1_result, r0seen);
      end
      drain(20);
   endtask

   task automatic test_contention();
      gnt_log.delete();
      run_ops(8, 8, 100);
      drain(50);
      n_vec++;
      if (gnt_log.size() != 16) begin
         n_err++;
         $display("FAIL contention_count: %0d grants want 16", gnt_log.size());
      end
      for (int i = 0; i < gnt_log.size(); i++) begin
         n_vec++;
         if (gnt_log[i] != i % 2) begin
            n_err++;
            $display("FAIL contention_order: grant[%0d]=%0d want %0d", i, gnt_log[i], i % 2);
         end
      end
   endtask

   task automatic test_backpressure();
      rsp0_ready = 0;
      run_ops(4, 0, 20);
      new_op0();
      req0_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_vec++;
         if ({req0_ready, u_din_valid, rsp0_valid} !== 3'b001) begin
            n_err++;
            $display("FAIL full_stall: ready=%b din_valid=%b rsp0_valid=%b want 0/0/1",
                     req0_ready, u_din_valid, rsp0_valid);
         end
         cyc();
      end
      rsp0_ready = 1;
      @(negedge clock);
      n_vec++;
      if ({rsp0_valid, req0_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL full_pop_no_push: rsp0_valid=%b req0_ready=%b want 1/0", rsp0_valid, req0_ready);
      end
      cyc();
      @(negedge clock);
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++;
         $display("FAIL resume_issue: req0_ready=%b want 1", req0_ready);
      end
      cyc();
      req0_valid = 0;
      drain(30);
   endtask

   task automatic test_unit_stall();
      int n;
      logic [31:0] held;
      unit_rdy = 0;
      new_op0();
      new_op1();
      held = req1_value;
      req0_valid = 1;
      req1_valid = 1;
      n = gnt_log.size();
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         n_vec++;
         if ({u_din_valid, req0_ready, req1_ready} !== 3'b100 || u_din_value !== held) begin
            n_err++;
            $display("FAIL stall_hold: v=%b r0=%b r1=%b value=%h want 1/0/0/%h",
                     u_din_valid, req0_ready, req1_ready, u_din_value, held);
         end
         cyc();
      end
      n_vec++;
      if (gnt_log.size() != n) begin
         n_err++;
         $display("FAIL stall_issue: %0d issues during stall want 0", gnt_log.size() - n);
      end
      unit_rdy = 1;
      @(negedge clock);
      n_vec++;
      if (req1_ready !== 1'b1 || u_din_value !== held) begin
         n_err++;
         $display("FAIL stall_release: req1_ready=%b value=%h want 1/%h", req1_ready, u_din_value, held);
      end
      cyc();
      req1_valid = 0;
      @(negedge clock);
      n_vec++;
      if (req0_ready !== 1'b1) begin
         n_err++;
         $display("FAIL stall_second: req0_ready=%b want 1", req0_ready);
      end
      cyc();
      req0_valid = 0;
      drain(30);
   endtask

   task automatic test_reset_midop();
      rsp0_ready = 0;
      rsp1_ready = 0;
      run_ops(3, 0, 20);
      new_op0();
      new_op1();
      req0_valid = 1;
      req1_valid = 1;
      #2 reset = 1;
      #1;
      n_vec++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, u_din_valid, u_dout_ready} !== 6'b0) begin
         n_err++;
         $display("FAIL async_reset: got %b want 000000", {req0_ready, req1_ready, rsp0_valid,
                  rsp1_valid, u_din_valid, u_dout_ready});
      end
      cyc();
      reset = 0;
      gnt_log.delete();
      run_ops(2, 2, 20);
      req0_valid = 1;
      req1_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         n_vec++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_full: r0=%b r1=%b want 0/0", req0_ready, req1_ready);
         end
         cyc();
      end
      req0_valid = 0;
      req1_valid = 0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if (gnt_log.size() != 4 || gnt_log[i] != i % 2) begin
            n_err++;
            $display("FAIL post_reset_order: grant[%0d] of %0d want %0d", i, gnt_log.size(), i % 2);
         end
      end
      drain(30);
   endtask

   initial begin
      test_reset();
      test_single_bext();
      test_single_bdep();
      test_contention();
      test_backpressure();
      test_unit_stall();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1);
   end

endmodule
